// File: rtl/char_lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD sequencer:
// FSM state encoding, LCD opcodes, power-up init ROM and a us->cycles helper.
package char_lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWER_WAIT,
      ST_INIT_LOAD,
      ST_SETUP,
      ST_EN_HIGH,
      ST_HOLD,
      ST_EXEC_WAIT,
      ST_IDLE
   } state_t;

   localparam logic [7:0] FUNC_SET_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] DISP_ON       = 8'h0C;  // display on, cursor off, blink off
   localparam logic [7:0] CLEAR         = 8'h01;
   localparam logic [7:0] ENTRY_INC     = 8'h06;  // increment address, no shift

   localparam int INIT_LEN = 6;

   // Entry 0 sits in the lowest byte so INIT_ROM[idx] reads in issue order.
   localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
      ENTRY_INC, CLEAR, DISP_ON, FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L
   };

   function automatic int unsigned us_to_cyc(input int unsigned us,
                                             input int unsigned cyc_per_us);
      return us * cyc_per_us;
   endfunction

endpackage

// File: rtl/char_lcd_cmd_fifo.sv
// Synchronous command FIFO placed in front of the LCD sequencer when
// CHAR_LCD_CMD_FIFO_EN is defined. Show-ahead read data, registered ready
// (not full) flag, pushes refused while full even if a pop happens the same cycle.
module char_lcd_cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_ready,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             r_ready;
   logic [AW:0]      w_count_nxt;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push & r_ready;
   assign w_pop   = i_pop & (r_count != '0);
   assign o_ready = r_ready;
   assign o_rdata = r_mem[r_rptr];
   assign o_empty = (r_count == '0);

   // Occupancy after this cycle's push/pop, used to precompute the ready flag.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + (AW+1)'(1);
      else if (!w_push && w_pop) w_count_nxt = r_count - (AW+1)'(1);
   end

   // Storage array; contents need no reset since pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   // Pointers, count and registered ready; reset flushes the FIFO.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ready <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt != (AW+1)'(DEPTH));
      end
   end

endmodule

// File: rtl/char_lcd_sequencer.sv
// HD44780 16x2 character LCD sequencer, 8-bit write-only bus.
// Runs the power-up init sequence after reset, then forwards {rs,data}
// writes from a valid/ready requester, generating setup / enable / hold
// and execution-wait timing with a single down-counter.
// Optional: define CHAR_LCD_CMD_FIFO_EN to put a 16-deep command FIFO in
// front of the FSM (writes accepted even during init).
module char_lcd_sequencer
   import char_lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 50000000,
   parameter int unsigned T_POWER_US   = 20000,
   parameter int unsigned T_INIT_US    = 4100,
   parameter int unsigned T_EXEC_US    = 40,
   parameter int unsigned T_LONG_US    = 1640,
   parameter int unsigned SETUP_CYC    = 2,
   parameter int unsigned EN_PULSE_CYC = 25,
   parameter int unsigned HOLD_CYC     = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic       i_cmd_rs,
   input  logic [7:0] i_cmd_data,
   output logic       o_init_done,
   output logic       o_busy,
   output logic [7:0] o_lcd_data,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic       o_lcd_en,
   output logic       o_lcd_on,
   output logic       o_lcd_blon
);

   localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1000000;
   localparam int unsigned P_POWER    = us_to_cyc(T_POWER_US, CYC_PER_US);
   localparam int unsigned P_INIT     = us_to_cyc(T_INIT_US,  CYC_PER_US);
   localparam int unsigned P_EXEC     = us_to_cyc(T_EXEC_US,  CYC_PER_US);
   localparam int unsigned P_LONG     = us_to_cyc(T_LONG_US,  CYC_PER_US);
   localparam int          CNT_W      = $clog2(P_POWER + 1);

   // A timed state lasting n cycles loads n-1 and leaves when it reads 0.
   function automatic logic [CNT_W-1:0] ld(input int unsigned n);
      return CNT_W'(n - 1);
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [8:0]       r_byte;       // {rs, data} of the write in flight
   logic             r_init_done;
   logic             r_busy;
   logic [7:0]       r_lcd_data;
   logic             r_lcd_rs;
   logic             r_lcd_en;
   logic             r_lcd_on;

   logic             w_req_valid;
   logic [8:0]       w_req_word;
   logic             w_take;
   logic [CNT_W-1:0] w_exec_ld;

   assign w_take = (r_state == ST_IDLE) && r_init_done && w_req_valid;

`ifdef CHAR_LCD_CMD_FIFO_EN
   logic w_fifo_ready;
   logic w_fifo_empty;

   char_lcd_cmd_fifo #(.DEPTH(16), .WIDTH(9)) u_cmd_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_cmd_valid),
      .i_wdata ({i_cmd_rs, i_cmd_data}),
      .o_ready (w_fifo_ready),
      .i_pop   (w_take),
      .o_rdata (w_req_word),
      .o_empty (w_fifo_empty)
   );

   assign w_req_valid = !w_fifo_empty;
   assign o_cmd_ready = w_fifo_ready;
`else
   logic r_cmd_ready;

   assign w_req_valid = i_cmd_valid & r_cmd_ready;
   assign w_req_word  = {i_cmd_rs, i_cmd_data};
   assign o_cmd_ready = r_cmd_ready;

   // Ready only while parked in IDLE after init; drops right after a transfer.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_cmd_ready <= 1'b0;
      else         r_cmd_ready <= (r_state == ST_IDLE) && r_init_done && !w_take;
   end
`endif

   // Execution wait for the byte just strobed: long init waits for the first
   // two function-sets, long command waits for clear/home, short otherwise.
   always_comb begin
      w_exec_ld = ld(P_EXEC);
      if (!r_init_done && (r_idx < 3'd2))            w_exec_ld = ld(P_INIT);
      else if (!r_byte[8] && (r_byte[7:2] == 6'd0))  w_exec_ld = ld(P_LONG);
   end

   // Main sequencer; LCD pins are registered one cycle behind the state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_POWER_WAIT;
         r_cnt       <= ld(P_POWER);
         r_idx       <= '0;
         r_byte      <= '0;
         r_init_done <= 1'b0;
         r_busy      <= 1'b0;
         r_lcd_data  <= '0;
         r_lcd_rs    <= 1'b0;
         r_lcd_en    <= 1'b0;
         r_lcd_on    <= 1'b0;
      end else begin
         r_lcd_on <= 1'b1;
         r_lcd_en <= (r_state == ST_EN_HIGH);
         r_busy   <= !((r_state == ST_IDLE) || (r_state == ST_POWER_WAIT));
         if (r_state == ST_SETUP) begin
            r_lcd_rs   <= r_byte[8];
            r_lcd_data <= r_byte[7:0];
         end

         case (r_state)
            ST_POWER_WAIT: begin
               if (r_cnt == '0) r_state <= ST_INIT_LOAD;
               else             r_cnt   <= r_cnt - CNT_W'(1);
            end
            ST_INIT_LOAD: begin
               r_byte  <= {1'b0, INIT_ROM[r_idx]};
               r_cnt   <= ld(SETUP_CYC);
               r_state <= ST_SETUP;
            end
            ST_SETUP: begin
               if (r_cnt == '0) begin
                  r_cnt   <= ld(EN_PULSE_CYC);
                  r_state <= ST_EN_HIGH;
               end else r_cnt <= r_cnt - CNT_W'(1);
            end
            ST_EN_HIGH: begin
               if (r_cnt == '0) begin
                  r_cnt   <= ld(HOLD_CYC);
                  r_state <= ST_HOLD;
               end else r_cnt <= r_cnt - CNT_W'(1);
            end
            ST_HOLD: begin
               if (r_cnt == '0) begin
                  r_cnt   <= w_exec_ld;
                  r_state <= ST_EXEC_WAIT;
               end else r_cnt <= r_cnt - CNT_W'(1);
            end
            ST_EXEC_WAIT: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
               else if (r_init_done) r_state <= ST_IDLE;
               else if (r_idx == 3'(INIT_LEN - 1)) begin
                  r_init_done <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= ST_INIT_LOAD;
               end
            end
            ST_IDLE: begin
               if (w_take) begin
                  r_byte  <= w_req_word;
                  r_cnt   <= ld(SETUP_CYC);
                  r_state <= ST_SETUP;
               end
            end
            default: r_state <= ST_POWER_WAIT;
         endcase
      end
   end

   assign o_init_done = r_init_done;
   assign o_busy      = r_busy;
   assign o_lcd_data  = r_lcd_data;
   assign o_lcd_rs    = r_lcd_rs;
   assign o_lcd_rw    = 1'b0;
   assign o_lcd_en    = r_lcd_en;
   assign o_lcd_on    = r_lcd_on;
   assign o_lcd_blon  = r_lcd_on;

endmodule
